// File: rtl/pe_acc_seq_pkg.sv
// Shared types and defaults for the PE accumulation sequencer: FSM state encoding,
// default widths and the signed-overflow detect used by the accumulator.
package pe_acc_seq_pkg;

    localparam int PE_DATA_W = 32;
    localparam int PE_CNT_W  = 16;

    // Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement add overflows when both operands share a sign the sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pe_acc_seq_if.sv
// Handshake bundle between the job issuer, the adder tree and the writeback stage.
interface pe_acc_seq_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_len;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_psum;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_ovf;

    modport slave (
        input  cfg_valid, cfg_len, in_valid, in_psum, out_ready,
        output cfg_ready, in_ready, out_valid, out_result, out_ovf
    );

    modport master (
        output cfg_valid, cfg_len, in_valid, in_psum, out_ready,
        input  cfg_ready, in_ready, out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/pe_acc_seq.sv
// Accumulates cfg_len partial sums from the adder tree into one dot-product result.
// All handshake outputs are registered and decode from the next FSM state.
module pe_acc_seq
    import pe_acc_seq_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int CNT_W  = PE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pe_acc_seq_if.slave      bus,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   sum;

    logic                cfg_ready_q, in_ready_q, out_valid_q, busy_q;
    logic [DATA_W-1:0]   out_result_q;

    assign sum = acc_q + bus.in_psum;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    len_d   = bus.cfg_len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.cfg_len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_ONE;
                    ovf_d = ovf_q | add_ovf(acc_q[DATA_W-1], bus.in_psum[DATA_W-1], sum[DATA_W-1]);
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over any handshake offered in the same cycle.
        if (flush) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            cfg_ready_q  <= 1'b1;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            cfg_ready_q  <= (state_d == ST_IDLE);
            in_ready_q   <= (state_d == ST_ACC);
            out_valid_q  <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
            // The accumulator is only visible while a result is offered.
            out_result_q <= (state_d == ST_DONE) ? acc_d : '0;
        end
    end

    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_ovf    = ovf_q;
    assign busy           = busy_q;
    assign beat_cnt       = cnt_q;

endmodule

// File: tb/tb_pe_acc_seq.sv
// Scoreboard bench for pe_acc_seq: jobs push expected result/overflow, the output
// monitor pops and compares on every out handshake.
module tb_pe_acc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        busy;
    logic [15:0] beat_cnt;

    pe_acc_seq_if #(.DATA_W(32), .CNT_W(16)) bus ();

    pe_acc_seq #(.DATA_W(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] sb [$];
    logic [31:0] ps [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compare every consumed result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                $display("txn: result=%h ovf=%0d (expected %h ovf=%0d)",
                         bus.out_result, bus.out_ovf, e[31:0], e[32]);
                chk("result", bus.out_result, e[31:0]);
                chk("ovf", 32'(bus.out_ovf), 32'(e[32]));
            end
        end
    end

    task automatic wait_in_ready();
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Full job: gap bubble cycles between beats, hold cycles of out_ready low.
    task automatic run_job(input int len, input int gap, input int hold);
        logic [31:0] acc = '0;
        logic [31:0] tmp;
        logic        ov = 1'b0;
        chk("cfg_ready", 32'(bus.cfg_ready), 32'd1);
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = 16'(len);
        tick();
        bus.cfg_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            tmp = acc + ps[i];
            ov  = ov | ((acc[31] == ps[i][31]) && (tmp[31] != acc[31]));
            acc = tmp;
            bus.in_valid = 1'b1;
            bus.in_psum  = ps[i];
            wait_in_ready();
            tick();
            bus.in_valid = 1'b0;
            chk("beat_cnt", 32'(beat_cnt), 32'(i + 1));
            if (i != len - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("beat_cnt_bubble", 32'(beat_cnt), 32'(i + 1));
                end
            end
        end
        sb.push_back({ov, acc});
        chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
        if (len == 0) chk("in_ready_len0", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_result", bus.out_result, acc);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_out_result", bus.out_result, 32'd0);
    endtask

    // Start a 4-beat job and consume one beat, leaving the block mid-ACC.
    task automatic start_partial(input logic [31:0] p);
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = 16'd4;
        tick();
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_psum   = p;
        tick();
        bus.in_valid  = 1'b0;
        chk("partial_busy", 32'(busy), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_psum   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_out_result", bus.out_result, 32'd0);
        chk("reset_out_ovf", 32'(bus.out_ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        ps[0] = 32'd10; ps[1] = 32'd20; ps[2] = -32'sd5;
        run_job(3, 0, 0);
        run_job(0, 0, 0);

        ps[0] = 32'h7FFF_FFFF; ps[1] = 32'd1;
        run_job(2, 0, 0);
        ps[0] = 32'd4;
        run_job(1, 0, 0);

        ps[0] = 32'd1; ps[1] = 32'd2; ps[2] = 32'd3; ps[3] = 32'd4;
        run_job(4, 2, 5);

        start_partial(32'd100);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_psum  = 32'd5;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk_idle("flush_acc");
        ps[0] = 32'd7;
        run_job(1, 0, 0);

        start_partial(32'd100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle("rst_mid");
        run_job(1, 0, 0);

        bus.cfg_valid = 1'b1;
        bus.cfg_len   = 16'd3;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.cfg_valid = 1'b0;
        chk_idle("flush_cfg");

        bus.cfg_valid = 1'b1;
        bus.cfg_len   = 16'd0;
        tick();
        bus.cfg_valid = 1'b0;
        chk("done_before_flush", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle("flush_done");

        ps[0] = 32'h8000_0000; ps[1] = 32'hFFFF_FFFF;
        run_job(2, 1, 0);
        ps[0] = 32'h7FFF_FFFF; ps[1] = 32'd1; ps[2] = 32'hFFFF_FFFF;
        run_job(3, 0, 2);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
